// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  alu_sequencer : issues 3-cycle register-to-register ops to a registered ALU
//  Rev 1.0
// ============================================================================
module alu_sequencer #(
  parameter int NREGS = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       instr_valid_i,
  input  logic [15:0] instr_i,
  output logic       instr_ready_o,
  input  logic       ld_en_i,
  input  logic [2:0] ld_addr_i,
  input  logic [7:0] ld_data_i,
  input  logic [2:0] dbg_addr_i,
  output logic [7:0] dbg_data_o,
  output logic [2:0] alu_op_o,
  output logic [7:0] alu_a_o,
  output logic [7:0] alu_b_o,
  input  logic [7:0] alu_out_i,
  input  logic [3:0] alu_flags_i,
  output logic [3:0] flags_q_o,
  output logic [7:0] result_q_o,
  output logic       done_o
);

  localparam int         AW      = 3;
  localparam logic [2:0] OP_COMP = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [2:0] dst_q, dst_d;
  logic [7:0] opa_q, opa_d;
  logic [7:0] opb_q, opb_d;
  logic [7:0] result_q, result_d;
  logic [3:0] flags_q, flags_d;
  logic       done_q, done_d;
  logic       wb_en;
  logic [7:0] rf_q [NREGS];

  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_i[3:0];

  assign instr_ready_o = (state_q == IDLE) && !rst_i;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dst_d    = dst_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    wb_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid_i && instr_ready_o) begin
          op_d    = instr_i[15:13];
          dst_d   = instr_i[12:10];
          opa_d   = rf_q[instr_i[9:7]];
          opb_d   = rf_q[instr_i[6:4]];
          state_d = EXEC;
        end
      end
      EXEC: state_d = CAPTURE;
      CAPTURE: begin
        result_d = alu_out_i;
        flags_d  = alu_flags_i;
        done_d   = 1'b1;
        wb_en    = (op_q != OP_COMP);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= 3'd0;
      dst_q    <= 3'd0;
      opa_q    <= 8'd0;
      opb_q    <= 8'd0;
      result_q <= 8'd0;
      flags_q  <= 4'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  // Writeback has priority over a host load aimed at the same entry.
  for (genvar i = 0; i < NREGS; i++) begin : g_rf
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        rf_q[i] <= 8'd0;
      end else if (wb_en && (dst_q == AW'(i))) begin
        rf_q[i] <= alu_out_i;
      end else if (ld_en_i && (ld_addr_i == AW'(i))) begin
        rf_q[i] <= ld_data_i;
      end
    end
  end

  // Operand registers only change on acceptance, so they hold between ops.
  assign alu_op_o   = op_q;
  assign alu_a_o    = opa_q;
  assign alu_b_o    = opb_q;
  assign dbg_data_o = rf_q[dbg_addr_i];
  assign flags_q_o  = flags_q;
  assign result_q_o = result_q;
  assign done_o     = done_q;

endmodule
`default_nettype wire
